// File: rtl/counter_sequencer.sv
// Round-robin arbiter/controller that drives a shared up/down counter to a requester's target.
// Latency: grant 1 cycle after request in IDLE; done pulses 1 cycle after the counter matches.
// Backpressure: request is a level held until done; dropping it mid-run aborts without done.
// Optional: define SEQ_STEP_LIMIT_EN to build a step counter that ends a stuck run with err.
module counter_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] target0,
    input  logic [WIDTH-1:0] target1,
    input  logic [WIDTH-1:0] q_in,
    output logic             cnt_enable,
    output logic             cnt_up_down,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic             gidx_q;      // index of the requester currently granted
    logic             rr_q;        // requester that wins when both ask
    logic [WIDTH-1:0] target_q;    // target captured at grant
    logic             up_q;
    logic [1:0]       gnt_q;
    logic [1:0]       done_q;

    logic             win_idx_d;
    logic [WIDTH-1:0] win_tgt_d;
    logic [1:0]       gnt_win_d;
    logic             match;
    logic             req_held;

    // Arbitration and run-condition decode
    always_comb begin
        win_idx_d = (req == 2'b11) ? rr_q : req[1];
        win_tgt_d = win_idx_d ? target1 : target0;
        gnt_win_d = win_idx_d ? 2'b10 : 2'b01;
        match     = (q_in == target_q);
        req_held  = req[gidx_q];
    end

    // The counter steps on the same edge it sees enable, so the enable has to
    // drop combinationally on the match cycle to avoid overshooting.
    assign cnt_enable  = ~reset & (state_q == S_RUN) & ~match & req_held;
    assign cnt_up_down = up_q;
    assign gnt         = gnt_q;
    assign done        = done_q;
    assign busy        = (state_q != S_IDLE);

`ifdef SEQ_STEP_LIMIT_EN
    logic [WIDTH:0] step_q;
    logic [WIDTH:0] step_d;
    logic           limit_hit;
    logic           err_q;

    // The run is given up on the enabled cycle that takes the count to 2**WIDTH.
    always_comb begin
        step_d    = step_q + {{WIDTH{1'b0}}, 1'b1};
        limit_hit = cnt_enable && (step_d == {1'b1, {WIDTH{1'b0}}});
    end

    // Count enabled run cycles; cleared while idle so every grant starts at zero
    always_ff @(posedge clock) begin
        if (reset) begin
            step_q <= '0;
        end else if (state_q == S_IDLE) begin
            step_q <= '0;
        end else if (cnt_enable) begin
            step_q <= step_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Sequencer FSM with registered grant, done, direction and error outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            gidx_q   <= 1'b0;
            rr_q     <= 1'b0;
            target_q <= '0;
            up_q     <= 1'b0;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
`ifdef SEQ_STEP_LIMIT_EN
            err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 2'b00;
`ifdef SEQ_STEP_LIMIT_EN
                    err_q  <= 1'b0;
`endif
                    if (req != 2'b00) begin
                        state_q  <= S_RUN;
                        gidx_q   <= win_idx_d;
                        gnt_q    <= gnt_win_d;
                        target_q <= win_tgt_d;
                        up_q     <= (win_tgt_d > q_in);
                    end
                end
                S_RUN: begin
                    // Abort takes priority over a same-cycle match
                    if (!req_held) begin
                        state_q <= S_IDLE;
                        gnt_q   <= 2'b00;
                        rr_q    <= ~gidx_q;
                    end else if (match) begin
                        state_q <= S_DONE;
                        done_q  <= gnt_q;
`ifdef SEQ_STEP_LIMIT_EN
                    end else if (limit_hit) begin
                        state_q <= S_DONE;
                        done_q  <= gnt_q;
                        err_q   <= 1'b1;
`endif
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    gnt_q   <= 2'b00;
                    done_q  <= 2'b00;
                    rr_q    <= ~gidx_q;
`ifdef SEQ_STEP_LIMIT_EN
                    err_q   <= 1'b0;
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= 2'b00;
                    done_q  <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Testbench for counter_sequencer: models the external 4-bit counter, checks every
// cycle against a transaction-level model, and pins the model with directed cases.
// Honours SEQ_STEP_LIMIT_EN the same way the design does.
module tb_counter_sequencer;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   req;
    logic [W-1:0] target0;
    logic [W-1:0] target1;
    logic [W-1:0] q_cnt;
    logic         cnt_enable;
    logic         cnt_up_down;
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic         busy;
    logic         err;

    logic         load_vld;
    logic [W-1:0] load_val;
    bit           stuck = 1'b0;
    bit           chk_on = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    counter_sequencer #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .target0     (target0),
        .target1     (target1),
        .q_in        (q_cnt),
        .cnt_enable  (cnt_enable),
        .cnt_up_down (cnt_up_down),
        .gnt         (gnt),
        .done        (done),
        .busy        (busy),
        .err         (err)
    );

    always #5 clock = ~clock;

    // External counter: loadable by the bench, optionally stuck, else steps when enabled
    always @(posedge clock) begin
        if (load_vld) q_cnt <= load_val;
        else if (cnt_enable && !stuck) q_cnt <= cnt_up_down ? q_cnt + 4'd1 : q_cnt - 4'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the counter, whether it is in its done
    // cycle, what it is aiming at, and whose turn it is when both ask.
    int           m_owner = -1;
    bit           m_fin   = 1'b0;
    bit           m_err   = 1'b0;
    logic [W-1:0] m_tgt   = '0;
    int           m_rr    = 0;
    bit           m_up    = 1'b0;
    int           m_steps = 0;

    initial begin
        forever begin
            logic [1:0] e_gnt;
            logic [1:0] e_done;
            logic       e_en;
            int         w;
            @(negedge clock);
            e_gnt  = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
            e_done = m_fin ? e_gnt : 2'b00;
            e_en   = (m_owner >= 0) ? (!reset && !m_fin && (q_cnt != m_tgt) && req[m_owner]) : 1'b0;
            if (chk_on) begin
                chk("cyc_gnt",  32'(gnt),         32'(e_gnt));
                chk("cyc_done", 32'(done),        32'(e_done));
                chk("cyc_busy", 32'(busy),        32'(m_owner >= 0));
                chk("cyc_err",  32'(err),         32'(m_fin && m_err));
                chk("cyc_en",   32'(cnt_enable),  32'(e_en));
                chk("cyc_up",   32'(cnt_up_down), 32'(m_up));
            end
            // advance the model to what must hold after the coming edge
            if (reset) begin
                m_owner = -1; m_fin = 0; m_err = 0; m_up = 0; m_tgt = '0; m_rr = 0;
            end else if (m_owner < 0) begin
                if (req != 2'b00) begin
                    w       = (req == 2'b11) ? m_rr : ((req == 2'b10) ? 1 : 0);
                    m_owner = w;
                    m_tgt   = (w == 1) ? target1 : target0;
                    m_up    = (m_tgt > q_cnt);
                    m_steps = 0;
                end
            end else if (m_fin) begin
                m_rr = 1 - m_owner; m_owner = -1; m_fin = 0; m_err = 0;
            end else if (!req[m_owner]) begin
                m_rr = 1 - m_owner; m_owner = -1;
            end else if (q_cnt == m_tgt) begin
                m_fin = 1;
            end else begin
                m_steps++;
`ifdef SEQ_STEP_LIMIT_EN
                if (m_steps == (1 << W)) begin
                    m_fin = 1; m_err = 1;
                end
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [W-1:0] v);
        load_vld = 1'b1;
        load_val = v;
        tick();
        load_vld = 1'b0;
    endtask

    // Wait for the done pulse, counting enabled cycles on the way
    task automatic run_txn(output int en_n, output logic [1:0] d, output logic e);
        en_n = 0; d = 2'b00; e = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done != 2'b00) begin
                d = done; e = err;
                return;
            end
            if (cnt_enable) en_n++;
            tick();
        end
        n_cmp++;
        n_err++;
        $display("FAIL txn_timeout: no done within 60 cycles, required a done pulse (t=%0t)", $time);
    endtask

    task automatic settle_idle();
        req = 2'b00;
        for (int i = 0; i < 10 && busy; i++) tick();
        tick();
    endtask

    initial begin
        int         n;
        logic [1:0] d;
        logic       e;
        int         idx;

        reset = 1'b1; req = 2'b00; target0 = '0; target1 = '0;
        load_vld = 1'b1; load_val = '0;
        tick();
        chk_on = 1'b1;
        chk("rst_gnt",  32'(gnt),         32'h0);
        chk("rst_done", 32'(done),        32'h0);
        chk("rst_busy", 32'(busy),        32'h0);
        chk("rst_up",   32'(cnt_up_down), 32'h0);
        chk("rst_en",   32'(cnt_enable),  32'h0);
        chk("rst_err",  32'(err),         32'h0);
        tick();
        reset = 1'b0; load_vld = 1'b0;
        tick();

        // count up 3 -> 9 for requester 0
        load(4'd3);
        target0 = 4'd9; req = 2'b01;
        tick();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_up",  32'(cnt_up_down), 32'h1);
        run_txn(n, d, e);
        chk("t1_steps", 32'(n), 32'd6);
        chk("t1_done",  32'(d), 32'h1);
        chk("t1_q",     32'(q_cnt), 32'd9);
        req = 2'b00;
        tick();
        chk("t1_busy_after", 32'(busy), 32'h0);
        chk("t1_done_once",  32'(done), 32'h0);

        // count down 12 -> 2 for requester 1
        load(4'd12);
        target1 = 4'd2; req = 2'b10;
        tick();
        chk("t2_up", 32'(cnt_up_down), 32'h0);
        run_txn(n, d, e);
        chk("t2_steps", 32'(n), 32'd10);
        chk("t2_done",  32'(d), 32'h2);
        chk("t2_q",     32'(q_cnt), 32'd2);
        settle_idle();

        // both requesting from reset: 0, then 1, then 0 again
        reset = 1'b1;
        load(4'd0);
        reset = 1'b0;
        target0 = 4'd5; target1 = 4'd5; req = 2'b11;
        tick();
        chk("t3_gnt_first", 32'(gnt), 32'h1);
        run_txn(n, d, e);
        chk("t3_steps0", 32'(n), 32'd5);
        chk("t3_done0",  32'(d), 32'h1);
        tick();
        run_txn(n, d, e);
        chk("t3_steps1", 32'(n), 32'd0);
        chk("t3_done1",  32'(d), 32'h2);
        tick();
        run_txn(n, d, e);
        chk("t3_done2", 32'(d), 32'h1);
        settle_idle();

        // already at target: zero-step transaction
        load(4'd7);
        target0 = 4'd7; req = 2'b01;
        tick();
        chk("t4_en_zero", 32'(cnt_enable), 32'h0);
        run_txn(n, d, e);
        chk("t4_steps", 32'(n), 32'd0);
        chk("t4_done",  32'(d), 32'h1);
        chk("t4_q",     32'(q_cnt), 32'd7);
        settle_idle();

        // abort after 4 steps of 0 -> 15
        load(4'd0);
        target0 = 4'd15; req = 2'b01;
        tick();
        repeat (4) tick();
        chk("t5_q_before", 32'(q_cnt), 32'd4);
        req = 2'b00;
        #1;
        chk("t5_en_drop", 32'(cnt_enable), 32'h0);
        tick();
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_gnt",  32'(gnt),  32'h0);
        chk("t5_done", 32'(done), 32'h0);
        chk("t5_q",    32'(q_cnt), 32'd4);
        tick();
        chk("t5_no_late_done", 32'(done), 32'h0);

        // counter stuck at 0 while aiming for 15
        load(4'd0);
        stuck = 1'b1;
        target0 = 4'd15; req = 2'b01;
        tick();
`ifdef SEQ_STEP_LIMIT_EN
        run_txn(n, d, e);
        chk("t6_steps", 32'(n), 32'd16);
        chk("t6_done",  32'(d), 32'h1);
        chk("t6_err",   32'(e), 32'h1);
`else
        repeat (30) tick();
        chk("t6_busy", 32'(busy), 32'h1);
        chk("t6_err",  32'(err),  32'h0);
        chk("t6_q",    32'(q_cnt), 32'd0);
`endif
        stuck = 1'b0;
        settle_idle();

        // randomized traffic, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 5) == 0) begin
                idx = int'($urandom_range(0, 1));
                req[idx] = ~req[idx];
            end
            target0  = W'($urandom);
            target1  = W'($urandom);
            load_vld = !busy && ($urandom_range(0, 9) == 0);
            load_val = W'($urandom);
            tick();
        end
        load_vld = 1'b0;
        reset = 1'b0;
        settle_idle();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Controller and arbiter for the shared 4-bit up/down counter. Two requesters each ask for the counter to be driven to a target value. The block grants one requester at a time (round-robin) and drives the counter's enable and up_down inputs until the counter output equals the target. It then pulses done to the granted requester.

Parameters:
WIDTH, 4, counter width; must match the counter instance.

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
req  in  2  per-requester request; level, held until done, dropping it aborts
target0  in  WIDTH  requester 0 target value; sampled at grant
target1  in  WIDTH  requester 1 target value; sampled at grant
q_in  in  WIDTH  counter output feedback (counter q_out)
cnt_enable  out  1  to counter enable; combinational from state, target_r and q_in
cnt_up_down  out  1  to counter up_down; 1 = count up, 0 = count down; registered
gnt  out  2  one-hot grant; registered
done  out  2  one-cycle completion pulse, indexed by requester
busy  out  1  high whenever state != IDLE
err  out  1  one-cycle step-limit error pulse (see Optional Feature)

Behaviour:
- Reset (sync, reset=1 at the edge): state=IDLE, gnt=0, done=0, err=0, cnt_up_down=0, target_r=0, rr_ptr=0 (requester 0 has priority). cnt_enable is therefore 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - If any req bit is set, the winner is g = the only requester, or, if both request, the one rr_ptr points to.
  - Next edge: gnt[g]=1, target_r=target_g, cnt_up_down=(target_g > q_in), state=RUN.
  - No req: stay in IDLE.
- RUN:
  - cnt_enable = (q_in != target_r) && req[g]. The counter steps on the same edge.
  - q_in == target_r: next state DONE. cnt_enable is already 0 that cycle, so the counter never overshoots.
  - req[g]==0 (abort): cnt_enable=0. Next edge: state=IDLE, gnt=0, rr_ptr=~g, no done.
  - Priority when both match and abort occur in the same cycle: abort wins.
- DONE: done[g]=1 and gnt[g] stays 1 for exactly one cycle. Next edge: state=IDLE, gnt=0, rr_ptr=~g.
- Grant latency: 1 cycle from req in IDLE to gnt.
- Run length: |target - q_in| enabled cycles.
- Done timing: one cycle after the match.
- Minimum cycle per transaction: IDLE -> RUN -> DONE -> IDLE, so 3 cycles when target == q_in at grant (zero steps).
- The counter never wraps: direction comes from a direct unsigned compare. Maximum steps = 2**WIDTH-1.
- req held high after done is re-arbitrated in IDLE. The other requester wins if it is also requesting.
- target inputs and the non-granted req are ignored outside IDLE.
- Reset asserted mid-RUN: the FSM returns to IDLE on that edge, and cnt_enable drops in the same cycle.
- cnt_up_down holds its last value in IDLE and DONE.

Optional Feature:
- Macro SEQ_STEP_LIMIT_EN.
- Defined:
  - A WIDTH+1-bit step counter clears at grant and increments on every RUN cycle with cnt_enable=1.
  - If it reaches 2**WIDTH without a match (counter stuck, disabled, or reset externally), the block goes to DONE with err=1 alongside done[g].
- Undefined: no step counter is built, err is tied 0, and RUN waits indefinitely for the match.

Test Plan:
- q_in=3, req=01, target0=9 -> gnt=01 1 cycle later, cnt_up_down=1, cnt_enable high for 6 cycles, q_in=9, done=01 for 1 cycle, busy low after.
- q_in=12, req=10, target1=2 -> cnt_up_down=0, 10 enabled cycles, done=10, q_in=2, no overshoot.
- req=11 from reset, targets 5/5 from q_in=0 -> requester 0 served first (5 steps). Requester 1 is granted next and completes with 0 steps, done=10. Third round with req=11 grants requester 0 again.
- q_in=7, target0=7, req=01 -> RUN with cnt_enable=0, done=01 on the following cycle, q_in unchanged.
- Requester 0 running 0 -> 15, drops req after 4 steps -> cnt_enable=0 that cycle, IDLE next edge, done=00, q_in=4.
- SEQ_STEP_LIMIT_EN defined, counter feedback held at 0, target0=15 -> after 16 enabled cycles, done=01 with err=1. Without the macro, busy stays high and err stays 0.
